// File: rtl/fifo_gray_status_pkg.sv
// Purpose: shared Gray/binary helpers and FIFO geometry for the Gray-pointer status block.
// Latency: pure functions, no state.
// Backpressure: n/a.
package fifo_gray_pkg;

   // Widest pointer the helpers handle; callers zero-extend narrower pointers.
   localparam int unsigned MAX_W = 32;

   // Number of entries addressed by a pointer that carries one extra wrap bit.
   function automatic int unsigned fifo_depth(input int unsigned w);
      return 32'd1 << (w - 32'd1);
   endfunction

   // Binary to reflected Gray code.
   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Reflected Gray code to binary; zero-extended inputs give zero-extended results.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // True when at most one bit is set, i.e. a legal single Gray step (or no step).
   function automatic logic gray_step_ok(input logic [MAX_W-1:0] diff);
      return (diff & (diff - 32'd1)) == '0;
   endfunction

endpackage

// File: rtl/fifo_gray_status_sync.sv
// Purpose: resettable flop chain carrying a Gray pointer into the opposite side's view.
// Latency: SYNC_STAGES cycles from d to q.
// Backpressure: none; samples every cycle.
module gray_sync #(
   parameter int unsigned width       = 10,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [width-1:0] d,
   output logic [width-1:0] q
);

   logic [SYNC_STAGES-1:0][width-1:0] stage;

   // Shift the pointer one stage per cycle; reset clears the whole chain at once.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stage <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_gray_status.sv
// Purpose: full/empty/count/almostFull and sticky error flags for a Gray-pointer FIFO.
// Latency: push at T -> pop__RDY at T+1+SYNC_STAGES; pop at T -> push__RDY at T+1+SYNC_STAGES.
// Backpressure: push/pop only forwarded to the counters while the matching RDY is high.
module fifo_gray_status
   import fifo_gray_pkg::*;
#(
   parameter int unsigned width       = 10,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned AF_MARGIN   = 4
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             push__ENA,
   output logic             push__RDY,
   input  logic             pop__ENA,
   output logic             pop__RDY,
   output logic             wInc__ENA,
   output logic             rInc__ENA,
   input  logic [width-1:0] wGray,
   input  logic [width-1:0] rGray,
   output logic [width-1:0] count,
   output logic             almostFull,
   output logic             overflowErr,
   output logic             underflowErr,
   output logic             grayErr,
   input  logic             clearErr__ENA
);

   localparam int unsigned     DEPTH     = fifo_depth(width);
   localparam logic [width-1:0] AF_LEVEL  = width'(DEPTH - AF_MARGIN);
   // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
   localparam logic [width-1:0] WRAP_FLIP = width'(3) << (width - 2);

   logic [width-1:0] r_sync;
   logic [width-1:0] w_sync;
   logic [width-1:0] w_prev;
   logic [width-1:0] r_prev;
   logic             full;
   logic             empty;
   logic             gray_bad;

   gray_sync #(.width(width), .SYNC_STAGES(SYNC_STAGES)) u_r_sync (
      .CLK  (CLK),
      .nRST (nRST),
      .d    (rGray),
      .q    (r_sync)
   );

   gray_sync #(.width(width), .SYNC_STAGES(SYNC_STAGES)) u_w_sync (
      .CLK  (CLK),
      .nRST (nRST),
      .d    (wGray),
      .q    (w_sync)
   );

   // Each side compares its own live pointer against the delayed opposite pointer,
   // so status can only be stale in the safe direction.
   assign full       = (wGray == (r_sync ^ WRAP_FLIP));
   assign empty      = (rGray == w_sync);
   assign push__RDY  = !full;
   assign pop__RDY   = !empty;
   assign wInc__ENA  = push__ENA && push__RDY;
   assign rInc__ENA  = pop__ENA && pop__RDY;

   // Occupancy as seen by the writer; wraps naturally modulo 2**width.
   assign count      = width'(gray2bin(MAX_W'(wGray)) - gray2bin(MAX_W'(r_sync)));
   assign almostFull = (count >= AF_LEVEL);

   assign gray_bad   = !gray_step_ok(MAX_W'(wGray ^ w_prev)) ||
                       !gray_step_ok(MAX_W'(rGray ^ r_prev));

   // Sticky error flags; a fresh error in the same cycle beats a clear request.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         overflowErr  <= 1'b0;
         underflowErr <= 1'b0;
         grayErr      <= 1'b0;
      end else begin
         if (push__ENA && !push__RDY) begin
            overflowErr <= 1'b1;
         end else if (clearErr__ENA) begin
            overflowErr <= 1'b0;
         end
         if (pop__ENA && !pop__RDY) begin
            underflowErr <= 1'b1;
         end else if (clearErr__ENA) begin
            underflowErr <= 1'b0;
         end
         if (gray_bad) begin
            grayErr <= 1'b1;
         end else if (clearErr__ENA) begin
            grayErr <= 1'b0;
         end
      end
   end

   // Remember last cycle's pointers so multi-bit jumps can be spotted.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         w_prev <= '0;
         r_prev <= '0;
      end else begin
         w_prev <= wGray;
         r_prev <= rGray;
      end
   end

endmodule
